// File: rtl/burst_ram_slave.sv
// Single-port burst memory slave: AW/W write bursts and AR/R read bursts, one burst in flight.
// Synchronous one-cycle memory read feeds a registered rdata at one beat per cycle.
module burst_ram_slave #(
   parameter int unsigned AWIDTH     = 32,
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned LWIDTH     = 8,
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] awaddr,
   input  logic [LWIDTH-1:0] awlen,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   input  logic              wlast,
   input  logic [AWIDTH-1:0] araddr,
   input  logic [LWIDTH-1:0] arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [DWIDTH-1:0] rdata,
   output logic              rvalid,
   input  logic              rready,
   output logic              rlast
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

   state_e                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d, rd_idx;
   logic [LWIDTH-1:0]       cnt_q, cnt_d;
   logic [DWIDTH-1:0]       rdata_q;
   logic                    rd_en, wr_en;
   logic [DEPTH_LOG2-1:0]   aw_idx, ar_idx;
   logic [DWIDTH-1:0]       mem_q [DEPTH];
   logic                    unused_addr_bits;

   assign aw_idx = awaddr[DEPTH_LOG2+1:2];
   assign ar_idx = araddr[DEPTH_LOG2+1:2];
   assign unused_addr_bits = ^{awaddr[AWIDTH-1:DEPTH_LOG2+2], awaddr[1:0],
                               araddr[AWIDTH-1:DEPTH_LOG2+2], araddr[1:0]};

   assign awready = (state_q == IDLE);
   assign arready = (state_q == IDLE) && !awvalid;
   assign wready  = (state_q == WRITE);
   assign rvalid  = (state_q == READ);
   assign rlast   = (state_q == READ) && (cnt_q == '0);
   assign rdata   = rdata_q;

   // idx_q tracks the beat being written, or the beat currently presented on R;
   // a read accept fetches idx_q+1 so the next beat is ready the following cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      rd_idx  = idx_q + 1'b1;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (awvalid) begin
               state_d = WRITE;
               idx_d   = aw_idx;
               cnt_d   = awlen;
            end else if (arvalid) begin
               state_d = READ;
               idx_d   = ar_idx;
               cnt_d   = arlen;
               rd_en   = 1'b1;
               rd_idx  = ar_idx;
            end
         end
         WRITE: begin
            if (wvalid) begin
               wr_en = 1'b1;
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q - 1'b1;
               if ((cnt_q == '0) || wlast) begin
                  state_d = IDLE;
               end
            end
         end
         READ: begin
            if (rready) begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  rd_en = 1'b1;
                  idx_d = idx_q + 1'b1;
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         if (rd_en) begin
            rdata_q <= mem_q[rd_idx];
         end
      end
   end

   // Memory contents survive reset; only the write strobe is suppressed during it.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[idx_q] <= wdata;
      end
   end
endmodule

// File: tb/tb_burst_ram_slave.sv
// Self-checking bench for burst_ram_slave: table of write bursts with readback, a read
// scoreboard queue, and hand-written sequences for arbitration and reset mid-read.
module tb_burst_ram_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic        arvalid, arready, rvalid, rready, rlast;

   burst_ram_slave #(
      .AWIDTH(32), .DWIDTH(32), .LWIDTH(8), .DEPTH_LOG2(4)
   ) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          len;
      int          wlast_at;
      logic [31:0] seed;
      logic [31:0] step;
      int          exp_beats;
   } wvec_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } rexp_t;

   logic [31:0] model [16];
   rexp_t       exp_q [$];
   wvec_t       tbl [6];
   int          n_pass = 0;
   int          n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic write_burst(input wvec_t v);
      int beats;
      int idx;
      idx = int'(v.addr[5:2]);
      @(posedge clk); #1;
      awaddr = v.addr; awlen = v.len[7:0]; awvalid = 1'b1;
      @(negedge clk);
      check("aw_handshake_awready", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      beats = 0;
      for (int b = 0; b <= v.len + 1; b++) begin
         wdata  = v.seed + v.step * b;
         wvalid = 1'b1;
         wlast  = (b == v.wlast_at);
         @(negedge clk);
         if (!wready) break;
         model[(idx + b) % 16] = wdata;
         beats++;
         @(posedge clk); #1;
      end
      check("w_extra_beat_wready", wready, 0);
      check("w_done_awready", awready, 1);
      wvalid = 1'b0; wlast = 1'b0;
      check("w_beats_accepted", beats, v.exp_beats);
   endtask

   task automatic read_burst(input logic [31:0] addr, input int len,
                             input logic [15:0] pat, input int pat_len);
      int idx;
      int cyc;
      int hs;
      rexp_t e;
      idx = int'(addr[5:2]);
      for (int b = 0; b <= len; b++) begin
         e.data = model[(idx + b) % 16];
         e.last = (b == len);
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      araddr = addr; arlen = len[7:0]; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      check("ar_handshake_arready", arready, 1);
      check("ar_cycle_rvalid", rvalid, 0);
      @(posedge clk); #1;
      arvalid = 1'b0;
      cyc = 0; hs = 0;
      while (exp_q.size() > 0 && cyc < 64) begin
         rready = (cyc < pat_len) ? pat[cyc] : 1'b1;
         @(negedge clk);
         check("r_rvalid", rvalid, 1);
         check("r_rdata", rdata, exp_q[0].data);
         check("r_rlast", rlast, exp_q[0].last);
         if (rready) begin
            void'(exp_q.pop_front());
            hs++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      check("r_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check("r_done_rvalid", rvalid, 0);
      check("r_done_rlast", rlast, 0);
      check("r_handshakes", hs, len + 1);
   endtask

   initial begin
      tbl[0] = '{addr: 32'h00,  len: 15, wlast_at: 15, seed: 32'h1000, step: 1,     exp_beats: 16};
      tbl[1] = '{addr: 32'h100, len: 3,  wlast_at: 3,  seed: 32'hA0,   step: 1,     exp_beats: 4};
      tbl[2] = '{addr: 32'h3C,  len: 1,  wlast_at: 1,  seed: 32'h11,   step: 32'h11, exp_beats: 2};
      tbl[3] = '{addr: 32'h20,  len: 3,  wlast_at: 1,  seed: 32'hB0,   step: 1,     exp_beats: 2};
      tbl[4] = '{addr: 32'h28,  len: 0,  wlast_at: 0,  seed: 32'hC0,   step: 1,     exp_beats: 1};
      tbl[5] = '{addr: 32'h10,  len: 3,  wlast_at: 99, seed: 32'hD0,   step: 1,     exp_beats: 4};

      rst = 1'b1;
      awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
      araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_awready", awready, 1);
      check("rst_arready", arready, 1);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_rdata", rdata, 0);

      for (int i = 0; i < 6; i++) begin
         write_burst(tbl[i]);
         read_burst(tbl[i].addr, tbl[i].len, 16'h0, 0);
      end

      // wrapped write left 0x22 at word 0
      read_burst(32'h0, 0, 16'h0, 0);
      // backpressure 1,0,0,1,1,0,1 (bit i = cycle i)
      read_burst(32'h100, 3, 16'b1011001, 7);

      // simultaneous AW/AR: write wins, read stays pending
      @(posedge clk); #1;
      awaddr = 32'h0; awlen = 8'd0; awvalid = 1'b1;
      araddr = 32'h0; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      check("both_awready", awready, 1);
      check("both_arready", arready, 0);
      @(posedge clk); #1;
      awvalid = 1'b0; wdata = 32'h55; wvalid = 1'b1; wlast = 1'b1;
      @(negedge clk);
      check("both_w_arready", arready, 0);
      check("both_wready", wready, 1);
      model[0] = 32'h55;
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge clk);
      check("both_ar_later_arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("both_rvalid", rvalid, 1);
      check("both_rdata", rdata, model[0]);
      check("both_rlast", rlast, 1);
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      check("both_done_rvalid", rvalid, 0);

      // reset during beat 2 of an 8-beat read
      @(posedge clk); #1;
      araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("rstmid_beat1", rdata, model[0]);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_beat2", rdata, model[1]);
      @(posedge clk); #1;
      rst = 1'b0; rready = 1'b0;
      @(negedge clk);
      check("rstmid_rvalid", rvalid, 0);
      check("rstmid_rlast", rlast, 0);
      check("rstmid_awready", awready, 1);
      check("rstmid_arready", arready, 1);
      read_burst(32'h4, 2, 16'h0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1);
   end
endmodule
